// File: rtl/pwm_meter_pkg.sv
// Shared types and constants for the PWM duty meter.
package pwm_meter_pkg;

  localparam int         DUTY_STEPS = 10;
  localparam logic [3:0] MAX_CODE   = 4'd9;

  typedef logic [3:0] code_t;

  typedef enum logic {
    CALC_IDLE,
    CALC_RUN
  } calc_state_t;

  typedef enum logic {
    MEAS_WAIT_EDGE,
    MEAS_RUN
  } meas_state_t;

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Signal bundle of the PWM duty meter: the waveform in, decoded results out.
// master = waveform source / result consumer, slave = the meter.
interface pwm_duty_meter_if #(
  parameter int CNT_W = 16
);
  import pwm_meter_pkg::*;

  logic             pwm_in;
  code_t            duty_code;
  logic             duty_valid;
  logic [CNT_W-1:0] period_out;
  logic             stuck;
  logic             stuck_lvl;
  logic             overrun;

  modport master (
    output pwm_in,
    input  duty_code, duty_valid, period_out, stuck, stuck_lvl, overrun
  );

  modport slave (
    input  pwm_in,
    output duty_code, duty_valid, period_out, stuck, stuck_lvl, overrun
  );

endinterface

// File: rtl/pwm_duty_calc.sv
// Shift-add compare engine: finds the nearest 10 % duty step for high time H
// over period P. Starting with acc = 3P it compares 20H against the step
// thresholds (2k+3)P one per cycle, so the result takes code+1 cycles.
// A new start is accepted in the same cycle that done is raised.
module pwm_duty_calc
  import pwm_meter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] h,
  input  logic [CNT_W-1:0] p,
  output logic             busy,
  output logic             done,
  output code_t            code,
  output logic [CNT_W-1:0] period
);

  // 21*P and 20*H both fit below 32*2^CNT_W
  localparam int ACC_W = CNT_W + 5;

  calc_state_t      state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W-1:0] h20, h20_nxt;
  logic [CNT_W-1:0] p_q, p_nxt;
  code_t            k, k_nxt;

  logic [ACC_W-1:0] h_ext, p_ext, p_q2;

  assign h_ext = ACC_W'(h);
  assign p_ext = ACC_W'(p);
  assign p_q2  = ACC_W'(p_q) << 1;

  // Engine state and working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CALC_IDLE;
      acc   <= '0;
      h20   <= '0;
      p_q   <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      h20   <= h20_nxt;
      p_q   <= p_nxt;
      k     <= k_nxt;
    end
  end

  // Step the threshold compare; a start overrides the return to idle
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    h20_nxt   = h20;
    p_nxt     = p_q;
    k_nxt     = k;
    done      = 1'b0;
    if (state == CALC_RUN) begin
      if ((h20 < acc) || (k == MAX_CODE)) begin
        done      = 1'b1;
        state_nxt = CALC_IDLE;
      end else begin
        acc_nxt = acc + p_q2;
        k_nxt   = k + 4'd1;
      end
    end
    if (start) begin
      state_nxt = CALC_RUN;
      acc_nxt   = p_ext + (p_ext << 1);
      h20_nxt   = (h_ext << 4) + (h_ext << 2);
      p_nxt     = p;
      k_nxt     = '0;
    end
  end

  assign busy   = (state == CALC_RUN);
  assign code   = k;
  assign period = p_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: synchronises an asynchronous PWM input, measures high time
// and period between rising edges and decodes the duty step (code k = (k+1)*10 %).
// One snapshot can wait in a pending slot while the calc engine is busy;
// losing one sets the sticky overrun flag.
// Optional build macro: PWM_METER_GLITCH_FILTER_EN rejects pulses shorter
// than two clocks after the synchroniser (adds two clocks of latency).
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int SYNC_STG = 2
) (
  input logic              clk,
  input logic              rst_n,
  pwm_duty_meter_if.slave  bus
);

  logic [SYNC_STG-1:0] sync_q;
  logic                sync_out;
  logic                s, s_d, rise;

  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic             per_sat, hi_sat;

  meas_state_t meas, meas_nxt;
  logic        snap, go_stuck;

  logic             pend_full, pend_load, pend_clr, ovr_set;
  logic [CNT_W-1:0] pend_h, pend_p;

  logic             calc_start, calc_busy, calc_done, calc_ready;
  logic [CNT_W-1:0] calc_h, calc_p, calc_period;
  code_t            calc_code;

  code_t            duty_code_q;
  logic             duty_valid_q, stuck_q, stuck_lvl_q, overrun_q;
  logic [CNT_W-1:0] period_q;

  // Input synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STG-2:0], bus.pwm_in};
  end

  assign sync_out = sync_q[SYNC_STG-1];

`ifdef PWM_METER_GLITCH_FILTER_EN
  logic sync_d;

  // Accept a new level only after two equal consecutive samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_d <= sync_out;
      if (sync_out == sync_d) s <= sync_out;
    end
  end
`else
  assign s = sync_out;
`endif

  // Delayed level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s;
  end

  assign rise    = s & ~s_d;
  assign per_sat = &per_cnt;
  assign hi_sat  = &hi_cnt;

  // Period/high counters; the rise cycle is the first cycle of the new period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (!per_sat)     per_cnt <= per_cnt + CNT_W'(1);
      if (s && !hi_sat) hi_cnt  <= hi_cnt + CNT_W'(1);
    end
  end

  // Measurement FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) meas <= MEAS_WAIT_EDGE;
    else        meas <= meas_nxt;
  end

  // Measurement FSM: first edge only arms, later edges snapshot, timeout -> stuck
  always_comb begin
    meas_nxt = meas;
    snap     = 1'b0;
    go_stuck = 1'b0;
    case (meas)
      MEAS_WAIT_EDGE: begin
        if (rise) meas_nxt = MEAS_RUN;
      end
      MEAS_RUN: begin
        if (rise) begin
          snap = 1'b1;
        end else if (per_sat) begin
          go_stuck = 1'b1;
          meas_nxt = MEAS_WAIT_EDGE;
        end
      end
      default: meas_nxt = MEAS_WAIT_EDGE;
    endcase
  end

  // Stuck flag tracks the synchronised level until the next rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else if (go_stuck) begin
      stuck_q     <= 1'b1;
      stuck_lvl_q <= s;
    end else if (stuck_q && rise) begin
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else if (stuck_q) begin
      stuck_lvl_q <= s;
    end
  end

  assign calc_ready = ~calc_busy | calc_done;

  // Route snapshots: pending slot feeds the engine first, newest snapshot wins the slot
  always_comb begin
    calc_start = 1'b0;
    calc_h     = hi_cnt;
    calc_p     = per_cnt;
    pend_load  = 1'b0;
    pend_clr   = 1'b0;
    ovr_set    = 1'b0;
    if (pend_full) begin
      if (calc_ready) begin
        calc_start = 1'b1;
        calc_h     = pend_h;
        calc_p     = pend_p;
        if (snap) pend_load = 1'b1;
        else      pend_clr  = 1'b1;
      end else if (snap) begin
        pend_load = 1'b1;
        ovr_set   = 1'b1;
      end
    end else if (snap) begin
      if (calc_ready) calc_start = 1'b1;
      else            pend_load  = 1'b1;
    end
  end

  // Pending slot and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_h    <= '0;
      pend_p    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (pend_load) begin
        pend_full <= 1'b1;
        pend_h    <= hi_cnt;
        pend_p    <= per_cnt;
      end else if (pend_clr) begin
        pend_full <= 1'b0;
      end
      if (ovr_set) overrun_q <= 1'b1;
    end
  end

  pwm_duty_calc #(
    .CNT_W (CNT_W)
  ) u_calc (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (calc_start),
    .h      (calc_h),
    .p      (calc_p),
    .busy   (calc_busy),
    .done   (calc_done),
    .code   (calc_code),
    .period (calc_period)
  );

  // Publish a finished measurement with a one-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_code_q  <= '0;
      period_q     <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      duty_valid_q <= calc_done;
      if (calc_done) begin
        duty_code_q <= calc_code;
        period_q    <= calc_period;
      end
    end
  end

  assign bus.duty_code  = duty_code_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.period_out = period_q;
  assign bus.stuck      = stuck_q;
  assign bus.stuck_lvl  = stuck_lvl_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Testbench for pwm_duty_meter: a cycle-level waveform model pushes the
// expected {code, period} at every modelled rising edge; a monitor pops and
// compares on each duty_valid pulse.
module tb_pwm_duty_meter;
  import pwm_meter_pkg::*;

  localparam int CNT_W    = 8;
  localparam int SYNC_STG = 2;
  localparam int SAT      = (1 << CNT_W) - 1;
`ifdef PWM_METER_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int T5_P = 6;
  localparam int T5_H = 4;
`else
  localparam bit FILT = 1'b0;
  localparam int T5_P = 4;
  localparam int T5_H = 3;
`endif

  typedef struct {
    int code;
    int per;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_duty_meter_if #(.CNT_W(CNT_W)) bus ();

  pwm_duty_meter #(
    .CNT_W    (CNT_W),
    .SYNC_STG (SYNC_STG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   valids = 0;
  int   last_exp_code = 0;

  // waveform model state
  bit m_raw_prev, m_lvl, m_armed;
  int m_hi, m_per;

  function automatic int exp_code(int h, int p);
    int c;
    c = (20 * h + p) / (2 * p) - 1;
    if (c < 0) c = 0;
    if (c > DUTY_STEPS - 1) c = DUTY_STEPS - 1;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_raw_prev = 1'b0;
    m_lvl      = 1'b0;
    m_armed    = 1'b0;
    m_hi       = 0;
    m_per      = 0;
  endtask

  task automatic drive_cycle(input bit lvl);
    bit eff;
    exp_t e;
    @(negedge clk);
    bus.pwm_in = lvl;
    eff = FILT ? ((lvl == m_raw_prev) ? lvl : m_lvl) : lvl;
    m_raw_prev = lvl;
    if (eff && !m_lvl) begin
      if (m_armed) begin
        e.code = exp_code(m_hi, m_per);
        e.per  = m_per;
        q.push_back(e);
      end
      m_armed = 1'b1;
      m_hi    = 0;
      m_per   = 0;
    end else if (m_armed && m_per == SAT) begin
      m_armed = 1'b0;
    end
    m_lvl = eff;
    if (m_per < SAT) m_per++;
    if (eff && m_hi < SAT) m_hi++;
  endtask

  task automatic pwm(input int per, input int hi, input int n);
    for (int j = 0; j < n; j++)
      for (int i = 0; i < per; i++) drive_cycle(i < hi);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (q.size() != 0 && t < 60) begin
      drive_cycle(1'b0);
      t++;
    end
    chk(tag, q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_code"},    bus.duty_code, 0);
    chk({tag, "_valid"},   bus.duty_valid, 0);
    chk({tag, "_period"},  bus.period_out, 0);
    chk({tag, "_stuck"},   bus.stuck, 0);
    chk({tag, "_lvl"},     bus.stuck_lvl, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.duty_valid === 1'b1) begin
        valids++;
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'(bus.duty_valid), 0);
        end else begin
          e = q.pop_front();
          last_exp_code = e.code;
          chk("duty_code", bus.duty_code, e.code);
          chk("period_out", bus.period_out, e.per);
        end
      end
    end
  end

  initial begin
    int v0;
    bus.pwm_in = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) drive_cycle(1'b0);

    // 20 % duty, period 10
    v0 = valids;
    pwm(10, 2, 6);
    drain("t1_drain");
    chk("t1_valid_count", valids - v0, 5);
    chk("t1_overrun", bus.overrun, 0);

    // sweep 10 % .. 80 %
    for (int h = 1; h <= 8; h++) pwm(10, h, 1);
    pwm(10, 5, 1);
    drain("t2_drain");

    // tie rounding, low and high limits
    pwm(20, 11, 2);
    pwm(20, 9, 2);
    pwm(20, 0, 1);
    pwm(40, 1, 1);
    pwm(20, 19, 1);
    pwm(20, 10, 1);
    drain("t3_drain");

    // stuck high, then resume
    repeat (300) drive_cycle(1'b1);
    chk("t4_stuck", bus.stuck, 1);
    chk("t4_stuck_lvl", bus.stuck_lvl, 1);
    chk("t4_code_held", bus.duty_code, last_exp_code);
    repeat (10) drive_cycle(1'b0);
    chk("t4_still_stuck", bus.stuck, 1);
    pwm(10, 5, 1);
    chk("t4_stuck_clear", bus.stuck, 0);
    pwm(10, 5, 3);
    drain("t4_drain");

    // one-clock spikes inside the low phase
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 20; i++) drive_cycle((i < 8) || (i == 13));
    pwm(20, 8, 1);
    drain("t6_drain");
    chk("t6_overrun", bus.overrun, 0);

    // short period with slow calc -> overrun, then reset mid-calc
    v0 = valids;
    pwm(T5_P, T5_H, 20);
    chk("t5_overrun", bus.overrun, 1);
    chk("t5_valid_seen", 32'(valids > v0 + 1), 1);
    drive_cycle(1'b1);
    rst_n = 1'b0;
    bus.pwm_in = 1'b0;
    q.delete();
    model_reset();
    @(negedge clk);
    chk_all_zero("t5_reset");
    rst_n = 1'b1;
    repeat (20) drive_cycle(1'b0);
    chk("t5_post_code", bus.duty_code, 0);
    chk("t5_post_overrun", bus.overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
